// File: rtl/sums_pkg.sv
// Shared sizing helpers and default parameters for the signed sum/accumulate pipeline.
// Tree lanes of every level are packed back-to-back in one flat bus; the offsets come from here.
package sums_pkg;

  localparam int DEF_I_DATA_W     = 32;
  localparam int DEF_O_DATA_W     = 39;
  localparam int DEF_O_REG_NUMBER = 2;

  function automatic int levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // The tree grows the magnitude by LEVELS bits; negating -2^(I-1) needs one more.
  function automatic bit width_ok(input int i_w, input int lv, input int o_w);
    return o_w >= i_w + lv + 1;
  endfunction

  function automatic int lanes_at(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int lane_off(input int n, input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) s += lanes_at(n, k);
    return s;
  endfunction

endpackage

// File: rtl/sums_add_level.sv
// One registered adder-tree level: N lanes in, ceil(N/2) pairwise sums out.
// An odd last lane is forwarded unchanged; valid and sideband ride along with the data.
module sums_add_level #(
  parameter int N    = 2,
  parameter int W    = 39,
  parameter int SB_W = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          vld_i,
  input  logic [SB_W-1:0]               side_i,
  input  logic [N*W-1:0]                dat_i,
  output logic                          vld_o,
  output logic [SB_W-1:0]               side_o,
  output logic [((N+1)/2)*W-1:0]        dat_o
);

  localparam int M = (N + 1) / 2;

  logic [M*W-1:0]  dat_d;
  logic [M*W-1:0]  dat_q;
  logic            vld_q;
  logic [SB_W-1:0] side_q;

  for (genvar k = 0; k < M; k++) begin : g_pair
    if (2 * k + 1 < N) begin : g_add
      assign dat_d[k*W +: W] = dat_i[2*k*W +: W] + dat_i[(2*k+1)*W +: W];
    end else begin : g_pass
      assign dat_d[k*W +: W] = dat_i[2*k*W +: W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      side_q <= '0;
    end else begin
      vld_q  <= vld_i;
      side_q <= side_i;
    end
  end

  always_ff @(posedge clk_i) begin
    dat_q <= dat_d;
  end

  assign vld_o  = vld_q;
  assign side_o = side_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/sums_pipe.sv
// Signed multi-lane add/subtract tree with optional running accumulator and output delay line.
// Fully pipelined, one beat per cycle, no backpressure; outputs hold their last valid value.
module sums_pipe
  import sums_pkg::*;
#(
  parameter int I_DATA_W     = DEF_I_DATA_W,
  parameter int I_DATA_SIZE  = 8,
  parameter int O_DATA_W     = DEF_O_DATA_W,
  parameter int O_REG_NUMBER = DEF_O_REG_NUMBER
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [I_DATA_W-1:0]    i_data [I_DATA_SIZE],
  input  logic [I_DATA_SIZE-1:0] i_sub_mask,
  input  logic                   i_acc_en,
  input  logic                   i_acc_clr,
  output logic                   o_valid,
  output logic [O_DATA_W-1:0]    o_data,
  output logic                   o_ovf
);

  localparam int LEVELS = levels(I_DATA_SIZE);
  localparam int W      = O_DATA_W;
  localparam int TOT    = lane_off(I_DATA_SIZE, LEVELS + 1);
  localparam int LAST   = lane_off(I_DATA_SIZE, LEVELS);

  if (!width_ok(I_DATA_W, LEVELS, O_DATA_W) || I_DATA_SIZE < 2 || O_REG_NUMBER < 1) begin : g_bad_cfg
    $error("sums_pipe: illegal parameters (O_DATA_W too narrow, I_DATA_SIZE < 2 or O_REG_NUMBER < 1)");
  end

  // Stage 0: sign-extend and conditionally negate every lane.
  logic [I_DATA_SIZE*W-1:0] s0_dat_d;
  logic [I_DATA_SIZE*W-1:0] s0_dat_q;
  logic [W-1:0]             s0_ext;
  logic                     s0_vld_q;
  logic [1:0]               s0_side_q;

  always_comb begin
    s0_dat_d = '0;
    s0_ext   = '0;
    for (int j = 0; j < I_DATA_SIZE; j++) begin
      s0_ext = {{(W - I_DATA_W){i_data[j][I_DATA_W-1]}}, i_data[j]};
      s0_dat_d[j*W +: W] = i_sub_mask[j] ? (~s0_ext + 1'b1) : s0_ext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s0_vld_q  <= 1'b0;
      s0_side_q <= '0;
    end else begin
      s0_vld_q  <= i_valid;
      s0_side_q <= {i_acc_en, i_acc_clr};
    end
  end

  always_ff @(posedge i_clk) begin
    s0_dat_q <= s0_dat_d;
  end

  // All tree levels live side by side in one flat bus, level l starting at lane_off(l).
  logic [TOT*W-1:0]       tree_dat;
  logic [LEVELS:0]        tree_vld;
  logic [LEVELS:0][1:0]   tree_side;

  assign tree_dat[I_DATA_SIZE*W-1:0] = s0_dat_q;
  assign tree_vld[0]                 = s0_vld_q;
  assign tree_side[0]                = s0_side_q;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = lanes_at(I_DATA_SIZE, l);
    localparam int NO = lanes_at(I_DATA_SIZE, l + 1);
    localparam int OI = lane_off(I_DATA_SIZE, l);
    localparam int OO = lane_off(I_DATA_SIZE, l + 1);

    sums_add_level #(
      .N    (NI),
      .W    (W),
      .SB_W (2)
    ) u_level (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .vld_i  (tree_vld[l]),
      .side_i (tree_side[l]),
      .dat_i  (tree_dat[OI*W +: NI*W]),
      .vld_o  (tree_vld[l+1]),
      .side_o (tree_side[l+1]),
      .dat_o  (tree_dat[OO*W +: NO*W])
    );
  end

  // Accumulate stage.
  logic [W-1:0] tree_sum;
  logic         acc_en_s;
  logic         acc_clr_s;
  logic [W-1:0] acc_base;
  logic [W-1:0] acc_sum;
  logic [W-1:0] acc_d, acc_q;
  logic [W-1:0] ac_res_d, ac_res_q;
  logic         ac_ovf_d, ac_ovf_q;
  logic         ac_vld_q;

  assign tree_sum               = tree_dat[LAST*W +: W];
  assign {acc_en_s, acc_clr_s}  = tree_side[LEVELS];

  always_comb begin
    acc_d    = acc_q;
    ac_res_d = ac_res_q;
    ac_ovf_d = ac_ovf_q;
    acc_base = acc_clr_s ? '0 : acc_q;
    acc_sum  = acc_base + tree_sum;
    if (tree_vld[LEVELS]) begin
      if (acc_en_s) begin
        acc_d    = acc_sum;
        ac_res_d = acc_sum;
        ac_ovf_d = (acc_base[W-1] == tree_sum[W-1]) && (acc_sum[W-1] != acc_base[W-1]);
      end else begin
        ac_res_d = tree_sum;
        ac_ovf_d = 1'b0;
        if (acc_clr_s) acc_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q    <= '0;
      ac_res_q <= '0;
      ac_ovf_q <= 1'b0;
      ac_vld_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ac_res_q <= ac_res_d;
      ac_ovf_q <= ac_ovf_d;
      ac_vld_q <= tree_vld[LEVELS];
    end
  end

  // Output delay line; payload only advances with a valid beat so the tail holds.
  logic [W-1:0]            dl_dat_q [O_REG_NUMBER];
  logic [O_REG_NUMBER-1:0] dl_vld_q;
  logic [O_REG_NUMBER-1:0] dl_ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < O_REG_NUMBER; i++) dl_dat_q[i] <= '0;
      dl_vld_q <= '0;
      dl_ovf_q <= '0;
    end else begin
      dl_vld_q[0] <= ac_vld_q;
      if (ac_vld_q) begin
        dl_dat_q[0] <= ac_res_q;
        dl_ovf_q[0] <= ac_ovf_q;
      end
      for (int i = 1; i < O_REG_NUMBER; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        if (dl_vld_q[i-1]) begin
          dl_dat_q[i] <= dl_dat_q[i-1];
          dl_ovf_q[i] <= dl_ovf_q[i-1];
        end
      end
    end
  end

  assign o_valid = dl_vld_q[O_REG_NUMBER-1];
  assign o_data  = dl_dat_q[O_REG_NUMBER-1];
  assign o_ovf   = dl_ovf_q[O_REG_NUMBER-1];

endmodule
